// File: rtl/wavegen_burst_ctrl.sv
// Per-channel run/burst sequencer for the waveform generator (one per channel).
// Arms or starts on the channel run bit, pulses phase_rst for one cycle, gates
// the channel output while running and counts wrap pulses down to zero.
// A cycles value of 0 gives continuous output.
//
// Ports:
//   S_AXI_ACLK     clock, all logic on the rising edge
//   S_AXI_ARESETN  asynchronous active-low reset
//   run_req        channel run bit (level)
//   trig_mode      0: start on run_req, 1: wait for trig
//   trig           single-cycle start strobe
//   cycles         burst length in waveform periods, 0 = continuous
//   wrap           single-cycle pulse per completed waveform period
//   phase_rst      one-cycle pulse clearing the datapath phase accumulator
//   out_en         channel output enable
//   busy           high while starting or running
//   done           one-cycle pulse on burst completion
//   trig_ovr       sticky flag: trig seen while starting or running
//   cycles_left    current down-counter value
module wavegen_burst_ctrl #(
    parameter int unsigned CYC_WIDTH = 16
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic                 run_req,
    input  logic                 trig_mode,
    input  logic                 trig,
    input  logic [CYC_WIDTH-1:0] cycles,
    input  logic                 wrap,
    output logic                 phase_rst,
    output logic                 out_en,
    output logic                 busy,
    output logic                 done,
    output logic                 trig_ovr,
    output logic [CYC_WIDTH-1:0] cycles_left
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CYC_WIDTH-1:0]   cnt_nxt;
    logic                   trig_ovr_nxt;

    // State register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter and overrun-flag logic
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cycles_left;
        trig_ovr_nxt = trig_ovr;

        // Dropping run_req aborts from anywhere and wins over trig/wrap.
        if (state != IDLE && !run_req) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (run_req) begin
                        state_nxt = trig_mode ? ARMED : START;
                    end
                end
                ARMED: begin
                    if (trig) begin
                        state_nxt = START;
                    end
                end
                START: begin
                    // Burst length is captured here; later writes only affect the next burst.
                    cnt_nxt   = cycles;
                    state_nxt = RUN;
                end
                RUN: begin
                    // A zero count in RUN can only mean continuous mode.
                    if (wrap && cycles_left != '0) begin
                        cnt_nxt = cycles_left - CYC_WIDTH'(1);
                        if (cycles_left == CYC_WIDTH'(1)) begin
                            state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (trig_mode && trig) begin
                        state_nxt = START;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        if (state_nxt == IDLE) begin
            trig_ovr_nxt = 1'b0;
        end else if (trig && (state == START || state == RUN)) begin
            trig_ovr_nxt = 1'b1;
        end
    end

    // Registered outputs, decoded from the upcoming state so they align with it
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            phase_rst   <= 1'b0;
            out_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            trig_ovr    <= 1'b0;
            cycles_left <= '0;
        end else begin
            phase_rst   <= (state_nxt == START);
            out_en      <= (state_nxt == RUN);
            busy        <= (state_nxt == START) || (state_nxt == RUN);
            done        <= (state_nxt == DONE) && (state != DONE);
            trig_ovr    <= trig_ovr_nxt;
            cycles_left <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wavegen_burst_ctrl.sv
// Self-checking bench for wavegen_burst_ctrl: a cycle model pushes the expected
// output vector when inputs are driven; it is popped and compared after the edge.
// Directed checks on top cover latency, counts and corner cases.
module tb_wavegen_burst_ctrl;

    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run_req;
    logic          trig_mode;
    logic          trig;
    logic [CW-1:0] cycles;
    logic          wrap;
    logic          phase_rst;
    logic          out_en;
    logic          busy;
    logic          done;
    logic          trig_ovr;
    logic [CW-1:0] cycles_left;

    int checks   = 0;
    int failures = 0;

    int done_seen;
    int en_seen;
    int en_low;
    int cl_nonzero;

    typedef enum int {M_IDLE, M_ARMED, M_START, M_RUN, M_DONE} mst_t;
    mst_t          m_st;
    logic [CW-1:0] m_cnt;
    logic          m_ovr;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    wavegen_burst_ctrl #(.CYC_WIDTH(CW)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .run_req       (run_req),
        .trig_mode     (trig_mode),
        .trig          (trig),
        .cycles        (cycles),
        .wrap          (wrap),
        .phase_rst     (phase_rst),
        .out_en        (out_en),
        .busy          (busy),
        .done          (done),
        .trig_ovr      (trig_ovr),
        .cycles_left   (cycles_left)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {11'd0, phase_rst, out_en, busy, done, trig_ovr, cycles_left};
    endfunction

    task automatic model_reset();
        m_st  = M_IDLE;
        m_cnt = '0;
        m_ovr = 1'b0;
    endtask

    // Reference behaviour for one clock edge using the inputs currently driven.
    task automatic model_step();
        mst_t ns;
        logic was_done;
        logic hot;
        ns       = m_st;
        was_done = (m_st == M_DONE);
        hot      = (m_st == M_START) || (m_st == M_RUN);
        if (m_st != M_IDLE && !run_req) begin
            ns = M_IDLE;
        end else begin
            case (m_st)
                M_IDLE:  if (run_req) ns = trig_mode ? M_ARMED : M_START;
                M_ARMED: if (trig) ns = M_START;
                M_START: begin m_cnt = cycles; ns = M_RUN; end
                M_RUN: begin
                    if (wrap && m_cnt != 0) begin
                        if (m_cnt == 1) ns = M_DONE;
                        m_cnt = m_cnt - 1'b1;
                    end
                end
                M_DONE:  if (trig_mode && trig) ns = M_START;
                default: ns = M_IDLE;
            endcase
        end
        if (ns == M_IDLE) m_ovr = 1'b0;
        else if (hot && trig) m_ovr = 1'b1;
        exp_q.push_back({11'd0, ns == M_START, ns == M_RUN, ns == M_START || ns == M_RUN,
                         ns == M_DONE && !was_done, m_ovr, m_cnt});
        m_st = ns;
    endtask

    // One clock: predict, let the edge happen, compare, clear strobes.
    task automatic tick(input string tag);
        logic [31:0] e;
        model_step();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, dut_vec(), e);
        end
        if (done)          done_seen++;
        if (out_en)        en_seen++;
        if (!out_en)       en_low++;
        if (cycles_left != 0) cl_nonzero++;
        trig = 1'b0;
        wrap = 1'b0;
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // n wrap pulses, each preceded by gap-1 quiet cycles.
    task automatic wraps(input int n, input int gap, input string tag);
        for (int i = 0; i < n; i++) begin
            ticks(gap - 1, tag);
            wrap = 1'b1;
            tick(tag);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run_req = 1'b0; trig_mode = 1'b0; trig = 1'b0;
        wrap = 1'b0; cycles = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", dut_vec(), 32'd0);
        rst_n = 1'b1;
        ticks(2, "idle");

        // Auto-start burst of 3
        cycles = 16'd3; trig_mode = 1'b0; run_req = 1'b1; done_seen = 0;
        tick("s2_start");
        check("s2_phase_pulse", {31'd0, phase_rst}, 32'd1);
        check("s2_en_not_yet", {31'd0, out_en}, 32'd0);
        tick("s2_run");
        check("s2_en_high", {31'd0, out_en}, 32'd1);
        check("s2_phase_single", {31'd0, phase_rst}, 32'd0);
        check("s2_loaded", 32'(cycles_left), 32'd3);
        for (int k = 1; k <= 3; k++) begin
            wraps(1, 10, "s2_wrap");
            check("s2_count", 32'(cycles_left), 32'(3 - k));
        end
        check("s2_en_fall", {31'd0, out_en}, 32'd0);
        check("s2_done_pulse", {31'd0, done}, 32'd1);
        ticks(5, "s2_hold");
        check("s2_done_once", 32'(done_seen), 32'd1);
        run_req = 1'b0;
        tick("s2_to_idle");
        check("s2_idle_busy", {31'd0, busy}, 32'd0);

        // Triggered burst of 2, then retrigger on the first DONE cycle
        cycles = 16'd2; trig_mode = 1'b1; run_req = 1'b1; en_seen = 0;
        ticks(20, "s3_armed");
        check("s3_armed_no_en", 32'(en_seen), 32'd0);
        trig = 1'b1;
        tick("s3_trig");
        check("s3_phase_pulse", {31'd0, phase_rst}, 32'd1);
        tick("s3_run");
        check("s3_loaded", 32'(cycles_left), 32'd2);
        wraps(2, 5, "s3_wrap");
        check("s3_done", {31'd0, done}, 32'd1);
        trig = 1'b1;
        tick("s3_retrig");
        check("s3_re_phase", {31'd0, phase_rst}, 32'd1);
        check("s3_re_no_done", {31'd0, done}, 32'd0);
        tick("s3_re_run");
        check("s3_reload", 32'(cycles_left), 32'd2);
        run_req = 1'b0;
        tick("s3_idle");

        // Continuous mode
        cycles = 16'd0; trig_mode = 1'b0; run_req = 1'b1;
        ticks(2, "s4_start");
        done_seen = 0; en_low = 0; cl_nonzero = 0;
        wraps(1000, 2, "s4_wrap");
        check("s4_en_steady", 32'(en_low), 32'd0);
        check("s4_no_done", 32'(done_seen), 32'd0);
        check("s4_cl_zero", 32'(cl_nonzero), 32'd0);
        run_req = 1'b0;
        tick("s4_stop");
        check("s4_en_off", {31'd0, out_en}, 32'd0);

        // run_req drop and final wrap in the same cycle
        cycles = 16'd4; run_req = 1'b1;
        ticks(2, "s5_start");
        wraps(3, 3, "s5_wrap");
        check("s5_cnt_one", 32'(cycles_left), 32'd1);
        done_seen = 0;
        run_req = 1'b0; wrap = 1'b1;
        tick("s5_abort");
        check("s5_abort_busy", {31'd0, busy}, 32'd0);
        tick("s5_after");
        check("s5_no_done", 32'(done_seen), 32'd0);

        // trig during RUN sets overrun without disturbing the burst
        cycles = 16'd3; run_req = 1'b1;
        ticks(2, "s5b_start");
        wraps(1, 3, "s5b_wrap");
        trig = 1'b1;
        tick("s5b_trig");
        check("s5b_ovr_set", {31'd0, trig_ovr}, 32'd1);
        check("s5b_cnt_kept", 32'(cycles_left), 32'd2);
        check("s5b_en_kept", {31'd0, out_en}, 32'd1);
        wraps(2, 3, "s5b_wrap");
        check("s5b_done", {31'd0, done}, 32'd1);
        check("s5b_ovr_sticky", {31'd0, trig_ovr}, 32'd1);
        run_req = 1'b0;
        tick("s5b_idle");
        check("s5b_ovr_clear", {31'd0, trig_ovr}, 32'd0);

        // cycles rewritten mid-burst; wrap during START ignored
        cycles = 16'd3; run_req = 1'b1;
        tick("s6_start");
        wrap = 1'b1;
        tick("s6_start_wrap");
        check("s6_start_wrap_ign", 32'(cycles_left), 32'd3);
        cycles = 16'd7;
        wraps(3, 4, "s6_wrap");
        check("s6_old_len_done", {31'd0, done}, 32'd1);
        run_req = 1'b0;
        tick("s6_idle");
        run_req = 1'b1;
        ticks(2, "s6_restart");
        check("s6_new_len", 32'(cycles_left), 32'd7);
        run_req = 1'b0;
        tick("s6_idle2");

        // Asynchronous reset mid-RUN
        cycles = 16'd5; run_req = 1'b1;
        ticks(2, "s7_start");
        wraps(2, 3, "s7_wrap");
        check("s7_cnt_three", 32'(cycles_left), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("s7_async_en", {31'd0, out_en}, 32'd0);
        check("s7_async_busy", {31'd0, busy}, 32'd0);
        check("s7_async_cnt", 32'(cycles_left), 32'd0);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick("s7_from_idle");
        check("s7_idle_start", {31'd0, phase_rst}, 32'd1);
        run_req = 1'b0;
        tick("s7_end");

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wavegen_burst_ctrl.md
Name: wavegen_burst_ctrl

Overview:
- Per-channel run/burst sequencer for the waveform generator; one instance per channel (A, B), in the AXI clock domain.
- Takes the channel's run bit, cycles count and trigger mode from the register block.
- Issues a phase-reset pulse to the waveform datapath, gates the channel output enable, counts completed waveform periods (wrap pulses) and stops after the programmed cycle count.
- Cycles = 0 means continuous output.

Parameters:
CYC_WIDTH, 16, width of cycles count and down-counter.

Ports:
S_AXI_ACLK  in  1  clock; all logic on rising edge.
S_AXI_ARESETN  in  1  asynchronous active-low reset.
run_req  in  1  level; channel run bit from register block.
trig_mode  in  1  0 = start as soon as run_req high; 1 = wait for trig.
trig  in  1  single-cycle start strobe, synchronous to S_AXI_ACLK.
cycles  in  CYC_WIDTH  burst length in waveform periods; 0 = continuous.
wrap  in  1  single-cycle pulse from datapath each completed period.
phase_rst  out  1  one-cycle pulse; datapath clears phase accumulator.
out_en  out  1  gates channel output (0 forces 16'd0 at output mux).
busy  out  1  high in START or RUN.
done  out  1  one-cycle pulse on burst completion.
trig_ovr  out  1  sticky; trig received while START/RUN.
cycles_left  out  CYC_WIDTH  current down-counter value.

Behaviour:
- States: IDLE, ARMED, START, RUN, DONE. State and all outputs are registered. Outputs decode from state:
  - phase_rst = (state==START)
  - out_en = (state==RUN)
  - busy = START|RUN
- Reset (asynchronous assert, synchronous release): state=IDLE; cnt=0; phase_rst=0, out_en=0, busy=0, done=0, trig_ovr=0.
- Priority rule: run_req=0 in any non-IDLE state → IDLE next edge; this overrides trig/wrap in the same cycle. Entering IDLE clears trig_ovr. cnt holds its value.
- IDLE:
  - run_req=1, trig_mode=0 → START.
  - run_req=1, trig_mode=1 → ARMED.
- ARMED: trig=1 → START. Otherwise hold.
- START: exactly one cycle. cnt <= cycles; cycles is latched here, and later writes do not affect the running burst. → RUN unconditionally. A wrap during START is ignored.
- RUN, cycles latched = 0: hold RUN indefinitely; cnt stays 0; wrap ignored.
- RUN, cycles latched ≠ 0, on wrap:
  - cnt==1 → cnt <= 0, → DONE.
  - otherwise cnt <= cnt-1.
- DONE: done=1 for the first DONE cycle only.
  - trig_mode=1 and trig=1 → START (retrigger; done and START may not overlap: a trig on the first DONE cycle still yields done=1 that cycle, then START).
  - trig_mode=0 → hold until run_req=0.
- trig in START or RUN: ignored for sequencing; sets trig_ovr.
- Latency, trig_mode=0: run_req sampled high at edge N → phase_rst high N..N+1 → out_en high from edge N+1.
- Latency, trig_mode=1: same timing, measured from the edge sampling trig.
- out_en falls on the edge that samples the final wrap or run_req=0. At most one cycle of extra output after the final wrap.
- trig_mode changes are only evaluated in IDLE/DONE; changing it mid-burst has no effect until then.
- No arithmetic beyond decrement. cnt never wraps below 0.

Test Plan:
- Reset mid-RUN (cycles=5, cnt=3): assert ARESETN low asynchronously → out_en, busy, cnt go 0 without waiting for a clock edge; after release, state is IDLE.
- trig_mode=0, cycles=3, run_req rises:
  - phase_rst single pulse next cycle, out_en high the cycle after.
  - Three wrap pulses spaced 10 cycles → cycles_left 3→2→1→0.
  - out_en falls on the edge of the 3rd wrap; done pulses once.
  - State holds DONE until run_req=0 → IDLE.
- trig_mode=1, cycles=2, run_req=1 → ARMED, out_en=0 for 20 cycles. trig → START/RUN. After 2 wraps → DONE. A second trig → new burst with phase_rst pulse and cycles_left reloaded to 2.
- cycles=0 continuous: 1000 wraps → out_en stays 1, cycles_left stays 0, done never asserts; run_req=0 → out_en 0 next edge.
- Simultaneous events in RUN (cycles=4, cnt=1): run_req=0 and wrap in the same cycle → IDLE, no done pulse. Separately, trig during RUN → trig_ovr=1, burst unaffected; trig_ovr clears on return to IDLE.
- Write cycles 3→7 during RUN → current burst still ends after 3 wraps; the next START loads 7.
